// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one 8x8 unsigned multiplier across NUM_REQ requesters.
// Define MUL_RR_PERF_EN to add the perf_issued_o / perf_stall_o counters.

module Eight_Bit_Mul (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   output logic [15:0] prod_o,
   output logic        carry_o
);
   logic [16:0] full;

   assign full    = {9'b0, a_i} * {9'b0, b_i};
   assign prod_o  = full[15:0];
   assign carry_o = full[16];
endmodule

module mul_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   input  logic [8*NUM_REQ-1:0] req_a_i,
   input  logic [8*NUM_REQ-1:0] req_b_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [15:0]          rsp_prod_o,
   output logic [ID_W-1:0]      rsp_id_o,
   output logic                 busy_o
`ifdef MUL_RR_PERF_EN
   ,
   output logic [15:0]          perf_issued_o,
   output logic [15:0]          perf_stall_o
`endif
);
   logic            s1_valid_q, s1_valid_d;
   logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
   logic [ID_W-1:0] op_id_q, op_id_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [15:0]     rsp_prod_q, rsp_prod_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;

   logic            drain, s2_en, s1_en, accept;
   logic            grant_vld;
   logic [ID_W-1:0] grant_idx, grant_nxt;
   logic [7:0]      a_lane [NUM_REQ];
   logic [7:0]      b_lane [NUM_REQ];
   logic [15:0]     mul_prod;
   logic            mul_carry;

   assign drain  = rsp_valid_q & rsp_ready_i;
   assign s2_en  = s1_valid_q & (~rsp_valid_q | drain);
   assign s1_en  = ~s1_valid_q | s2_en;
   assign accept = grant_vld & s1_en & ~rst_i;

   // Two passes split at rr_ptr give the rotating priority without a modulo.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && req_valid_i[i] && (i >= int'(rr_ptr_q))) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && req_valid_i[i] && (i < int'(rr_ptr_q))) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(i);
         end
      end
   end

   assign grant_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign a_lane[g]      = req_a_i[8*g +: 8];
      assign b_lane[g]      = req_b_i[8*g +: 8];
      assign req_ready_o[g] = accept & (grant_idx == ID_W'(g));
   end

   Eight_Bit_Mul u_mul (
      .a_i     (op_a_q),
      .b_i     (op_b_q),
      .prod_o  (mul_prod),
      .carry_o (mul_carry)
   );

   always_comb begin
      s1_valid_d  = s1_valid_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_id_d     = op_id_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_prod_d  = rsp_prod_q;
      rsp_id_d    = rsp_id_q;
      if (s1_en) begin
         if (accept) begin
            op_a_d     = a_lane[grant_idx];
            op_b_d     = b_lane[grant_idx];
            op_id_d    = grant_idx;
            s1_valid_d = 1'b1;
            rr_ptr_d   = grant_nxt;
         end else begin
            s1_valid_d = 1'b0;
         end
      end
      // A stalled result keeps its product and id untouched.
      if (s2_en) begin
         rsp_prod_d  = mul_prod;
         rsp_id_d    = op_id_q;
         rsp_valid_d = 1'b1;
      end else if (drain) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q  <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_id_q     <= '0;
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_prod_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_id_q     <= op_id_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_prod_q  <= rsp_prod_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_prod_o  = rsp_prod_q;
   assign rsp_id_o    = rsp_id_q;
   assign busy_o      = s1_valid_q | rsp_valid_q;

`ifdef MUL_RR_PERF_EN
   logic [15:0] issued_q, issued_d, stall_q, stall_d;

   always_comb begin
      issued_d = accept ? issued_q + 16'd1 : issued_q;
      stall_d  = stall_q;
      if (rsp_valid_q && !rsp_ready_i && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         issued_q <= issued_d;
         stall_q  <= stall_d;
      end
   end

   assign perf_issued_o = issued_q;
   assign perf_stall_o  = stall_q;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i && s1_valid_q) assert (mul_carry == 1'b0) else $error("multiplier carry set");
   end
`endif
endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: scoreboard with round-robin / occupancy reference model plus directed cases.
module tb_mul_rr_scheduler;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid, req_ready;
   logic [31:0]   req_a, req_b;
   logic          rsp_valid, rsp_ready, busy;
   logic [15:0]   rsp_prod;
   logic [1:0]    rsp_id;
`ifdef MUL_RR_PERF_EN
   logic [15:0]   perf_issued, perf_stall;
`endif

   mul_rr_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_prod_o  (rsp_prod),
      .rsp_id_o    (rsp_id),
      .busy_o      (busy)
`ifdef MUL_RR_PERF_EN
      ,
      .perf_issued_o (perf_issued),
      .perf_stall_o  (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {int id; int prod;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0;
   int n_acc = 0, n_drn = 0, rr = 0;
   bit prev_stall = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      sb.delete();
      n_acc = 0;
      n_drn = 0;
      rr = 0;
      prev_stall = 1'b0;
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
      @(posedge clk);
      #1;
      req_valid = v;
      req_a = a;
      req_b = b;
      rsp_ready = rdy;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || sb.size() != 0) && t < 50) begin
         @(posedge clk);
         t++;
      end
      chk("drain_timeout", 32'(t < 50), 32'd1);
   endtask

   // Reference arbiter: first valid requester from rr; pipe takes an op unless two are in flight and the output is stalled.
   always @(negedge clk) begin
      if (!rst) begin : acc_chk
         int g, occ;
         bit found;
         logic [N-1:0] er;
         found = 1'b0;
         g = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(rr + k) % N]) begin
               found = 1'b1;
               g = (rr + k) % N;
            end
         end
         occ = n_acc - n_drn;
         er = '0;
         if (found && (occ < 2 || rsp_ready)) er[g] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(er));
         if (er != '0) begin
            sb.push_back('{g, int'(req_a[8*g +: 8]) * int'(req_b[8*g +: 8])});
            n_acc++;
            rr = (g + 1) % N;
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("rsp_hold", 32'(rsp_valid), 32'd1);
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got id %0d prod %0h expected nothing", rsp_id, rsp_prod);
            end else begin
               chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
               chk("rsp_prod", 32'(rsp_prod), 32'(sb[0].prod));
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  n_drn++;
               end
            end
         end
         prev_stall = rsp_valid & ~rsp_ready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [15:0] t5_exp [3];
   int a0, d0;

   initial begin
      t5_exp[0] = 16'hFE01;
      t5_exp[1] = 16'h0000;
      t5_exp[2] = 16'h0100;
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      clear_model();
      #3;
      req_valid = '1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      req_valid = '0;
      rst = 1'b0;

      // T2: single op from requester 1, two cycles of latency, one-cycle result
      drive(4'b0010, 32'h0000_0D00, 32'h0000_0B00, 1'b1);
      @(negedge clk);
      chk("t2_accept", 32'(req_ready), 32'h2);
      drive('0, '0, '0, 1'b1);
      @(negedge clk);
      chk("t2_early", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("t2_valid", 32'(rsp_valid), 32'd1);
      chk("t2_prod", 32'(rsp_prod), 32'd143);
      chk("t2_id", 32'(rsp_id), 32'd1);
      @(negedge clk);
      chk("t2_once", 32'(rsp_valid), 32'd0);
      wait_idle();

      // T1: reset with ops in flight, before any result appears
      drive('1, $urandom, $urandom, 1'b1);
      @(posedge clk);
      #7;
      rst = 1'b1;
      clear_model();
      #1;
      chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("t1_first_grant", 32'(req_ready), 32'h1);

      // T3: all requesters valid, full throughput
      a0 = n_acc;
      d0 = n_drn;
      repeat (20) @(posedge clk);
      #1;
      chk("t3_accepts", 32'(n_acc - a0), 32'd20);
      chk("t3_results", 32'(n_drn - d0), 32'd18);
      drive('0, '0, '0, 1'b1);
      wait_idle();

      // T4: backpressure under full load
      drive('1, $urandom, $urandom, 1'b0);
      a0 = n_acc;
      repeat (5) @(posedge clk);
      #1;
      chk("t4_accepts", 32'(n_acc - a0), 32'd2);
      chk("t4_ready_low", 32'(req_ready), 32'd0);
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_prod_held", 32'(rsp_prod), 32'(sb[0].prod));
      drive('0, '0, '0, 1'b1);
      wait_idle();
      chk("t4_none_lost", 32'(n_drn), 32'(n_acc));

      // T5: operand extremes from requester 0
      fork
         begin
            drive(4'b0001, 32'h0000_00FF, 32'h0000_00FF, 1'b1);
            drive(4'b0001, 32'h0000_0000, 32'h0000_00FF, 1'b1);
            drive(4'b0001, 32'h0000_0080, 32'h0000_0002, 1'b1);
            drive('0, '0, '0, 1'b1);
         end
         begin
            for (int k = 0; k < 3; k++) begin
               int t = 0;
               @(negedge clk);
               #2;
               while (!rsp_valid && t < 10) begin
                  @(negedge clk);
                  #2;
                  t++;
               end
               chk("t5_prod", 32'(rsp_prod), 32'(t5_exp[k]));
            end
         end
      join
      wait_idle();

      // randomized traffic and backpressure against the reference model
      for (int c = 0; c < 400; c++)
         drive(N'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0));
      drive('0, '0, '0, 1'b1);
      wait_idle();
      chk("rand_none_lost", 32'(n_drn), 32'(n_acc));

`ifdef MUL_RR_PERF_EN
      // T6: 10 accepts then 4 stalled output cycles
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_model();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) drive(4'b0001, $urandom, $urandom, 1'b1);
      drive('0, '0, '0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_idle();
      chk("t6_issued", 32'(perf_issued), 32'd10);
      chk("t6_stall", 32'(perf_stall), 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
